// File: rtl/counter_pkg.sv
// counter_pkg: shared direction/mode constants and terminal-value helper for counter blocks
package counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
  function automatic int term_val(input int modulus, input logic dir);
    return (dir == DIR_UP) ? modulus - 1 : 0;
  endfunction
endpackage

// File: rtl/counter_next_val.sv
// counter_next_val: next count value with modulus wrap or saturation at the terminal value
module counter_next_val
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 16,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic [WIDTH-1:0] nxt,
  output logic             at_term
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  always_comb begin
    at_term = q == WIDTH'(term_val(MODULUS, up));
    nxt = at_term ? ((SATURATE == MODE_SAT) ? q : ((up == DIR_UP) ? '0 : MAXV))
                  : ((up == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1));
  end
endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: cascadable up/down modulus counter with load clamp, sync clear and terminal-count pulse
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 16,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             CLK,
  input  logic             CLRBAR,
  input  logic             SCLR,
  input  logic             LOADBAR,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic [WIDTH-1:0] DIC,
  output logic [WIDTH-1:0] QC,
  output logic             RCO,
  output logic             TC_PULSE
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be 2..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("updown_counter_param: MODULUS must be 2..2**WIDTH");
  end
  logic [WIDTH-1:0] qc_q, qc_d, nxt;
  logic             tc_q, tc_d, at_term, cnt_en, dic_ok;
  counter_next_val #(.WIDTH(WIDTH), .MODULUS(MODULUS), .SATURATE(SATURATE)) u_next (
    .q(qc_q),
    .up(UP),
    .nxt(nxt),
    .at_term(at_term)
  );
  always_comb begin
    cnt_en = ENP & ENT;
    dic_ok = 32'(DIC) < 32'(MODULUS);
    qc_d = SCLR ? '0 : !LOADBAR ? (dic_ok ? DIC : MAXV) : cnt_en ? nxt : qc_q;
    tc_d = !SCLR & LOADBAR & cnt_en & at_term;
  end
  always_ff @(posedge CLK or negedge CLRBAR) begin
    if (!CLRBAR) begin
      qc_q <= '0;
      tc_q <= 1'b0;
    end else begin
      qc_q <= qc_d;
      tc_q <= tc_d;
    end
  end
  assign QC = qc_q;
  assign RCO = ENT & at_term;
  assign TC_PULSE = tc_q;
endmodule
